// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit in front of a word-addressed data memory
// with an asynchronous read port and no byte enables.
//
// Handles one request at a time: word/byte loads (byte loads sign- or
// zero-extended) and word/byte stores. A byte store is a read-modify-write
// over two cycles (ACCESS reads the word, MERGE writes it back with one lane
// replaced). Every request ends in a single RESP cycle with resp_valid high.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_*                request from execute (valid/ready handshake)
//   resp_valid/data/err  one-cycle completion to writeback
//   mem_*                data memory port (mem_rdata is combinational)
//
// Optional build macro LSU_MISALIGN_TRAP_EN: word accesses with addr[0]=1
// skip the memory and complete with resp_err=1, resp_data=0. Without it,
// resp_err is constant 0 and misaligned word addresses are silently aligned.
//
// DW must be 16: the byte lanes are hard-wired to [7:0] and [15:8].
module lsu_mem_stage #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic          req_byte,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_MERGE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state;
  logic          r_we, r_byte, r_signed;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] rmw_word;

  logic          accept;
  logic          misalign;
  logic [7:0]    lane;
  logic [DW-1:0] load_val;
  logic [DW-1:0] merged;
  logic          word_store;

  assign req_ready  = (state == S_IDLE);
  assign accept     = req_valid && req_ready;
  assign word_store = r_we && !r_byte;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = !r_byte && r_addr[0];
`else
  assign misalign = 1'b0;
`endif

  // Little-endian lane select: odd byte address lives in the high lane.
  assign lane     = r_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
  assign load_val = !r_byte   ? mem_rdata :
                    r_signed  ? {{(DW-8){lane[7]}}, lane} :
                                {{(DW-8){1'b0}}, lane};
  assign merged   = r_addr[0] ? {r_wdata[7:0], rmw_word[7:0]} :
                                {rmw_word[DW-1:8], r_wdata[7:0]};

  // Memory strobes are gated by rst so an in-flight store never commits
  // on the edge that takes the reset.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = r_wdata;
    if (!rst) begin
      if (state == S_ACCESS) begin
        mem_addr  = {r_addr[AW-1:1], 1'b0};
        mem_read  = !misalign && !word_store;
        mem_write = !misalign && word_store;
      end else if (state == S_MERGE) begin
        mem_addr  = {r_addr[AW-1:1], 1'b0};
        mem_write = 1'b1;
        mem_wdata = merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      r_we       <= 1'b0;
      r_byte     <= 1'b0;
      r_signed   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      rmw_word   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          r_we     <= req_we;
          r_byte   <= req_byte;
          r_signed <= req_signed;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          state    <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!misalign && r_we && r_byte) begin
            rmw_word <= mem_rdata;
            state    <= S_MERGE;
          end else begin
            // Stores and faulted accesses report zero data.
            resp_data  <= (misalign || r_we) ? '0 : load_val;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_MERGE: begin
          resp_data  <= '0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Fault flag is set at completion and held until the next accept.
  always_ff @(posedge clk) begin
    if (rst)                               resp_err <= 1'b0;
    else if (accept)                       resp_err <= 1'b0;
    else if (state == S_ACCESS && misalign) resp_err <= 1'b1;
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [15:0] resp_data;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte(req_byte), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Environment memory: async read, commit at posedge.
  bit [15:0] mem [0:32767];
  assign mem_rdata = mem[mem_addr[15:1]];
  always @(posedge clk) if (mem_write) mem[mem_addr[15:1]] <= mem_wdata;

  // Reference model state.
  bit [15:0] ref_mem [0:32767];
  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          pending = 0;
  bit          c_we, c_byte, c_sgn, c_mis;
  logic [15:0] c_addr, c_wdata;
  int          acc_cyc, due, resp_count = 0, last_lat = 0;
  logic [15:0] last_data;
  logic        last_err;
  int          acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ext_load(input logic [15:0] w, input bit byt, input bit sgn, input bit a0);
    logic [7:0] b;
    if (!byt) return w;
    b = a0 ? w[15:8] : w[7:0];
    return sgn ? {{8{b[7]}}, b} : {8'h00, b};
  endfunction

  // Compare process: every cycle, after reset has been seen once.
  initial begin
    logic [15:0] w, exp_d;
    logic        exp_e;
    int          wi;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 0;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_strobes", {mem_read, mem_write}, 0);
        continue;
      end
      chk("req_ready", req_ready, !pending);
      chk("rw_exclusive", mem_read && mem_write, 0);
      if (!pending) chk("idle_mem_port", {mem_read, mem_write, mem_addr}, 0);
      if (pending && (mem_read || mem_write))
        chk("mem_addr", mem_addr, {c_addr[15:1], 1'b0});
      if (pending && c_mis) chk("misalign_no_access", {mem_read, mem_write}, 0);
      if (pending && cyc == due) begin
        wi = c_addr[15:1];
        w  = ref_mem[wi];
        exp_e = c_mis;
        if (c_mis)      exp_d = '0;
        else if (!c_we) exp_d = ext_load(w, c_byte, c_sgn, c_addr[0]);
        else begin
          exp_d = '0;
          if (!c_byte)       ref_mem[wi] = c_wdata;
          else if (c_addr[0]) ref_mem[wi] = {c_wdata[7:0], w[7:0]};
          else               ref_mem[wi] = {w[15:8], c_wdata[7:0]};
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_data", resp_data, exp_d);
        chk("resp_err", resp_err, exp_e);
        chk("mem_word", mem[wi], ref_mem[wi]);
        last_data = resp_data;
        last_err  = resp_err;
        last_lat  = cyc - acc_cyc;
        resp_count++;
        pending = 0;
      end else begin
        chk("resp_valid_quiet", resp_valid, 0);
      end
      if (req_valid && req_ready) begin
        c_we = req_we; c_byte = req_byte; c_sgn = req_signed;
        c_addr = req_addr; c_wdata = req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        c_mis = !req_byte && req_addr[0];
`else
        c_mis = 0;
`endif
        pending = 1;
        acc_cyc = cyc;
        due = cyc + ((c_we && c_byte && !c_mis) ? 3 : 2);
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic do_req(input bit we, input bit byt, input bit sgn,
                        input logic [15:0] a, input logic [15:0] d, input bit keep);
    bit got = 0;
    req_we = we; req_byte = byt; req_signed = sgn; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    bit done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (!pending) begin done = 1; break; end
    end
    if (!done) chk("resp_timeout", 0, 1);
  endtask

  initial begin
    int base, rc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", req_ready, 1);
    chk("reset_resp", {resp_valid, resp_err, resp_data}, 0);
    chk("reset_mem_addr", mem_addr, 0);
    @(posedge clk); #1;

    // Word store then load.
    do_req(1, 0, 0, 16'h0004, 16'hBEEF, 0); wait_resp();
    chk("wstore_latency", last_lat, 2);
    do_req(0, 0, 0, 16'h0004, 16'h0000, 0); wait_resp();
    chk("wload_data", last_data, 16'hBEEF);
    chk("wload_latency", last_lat, 2);

    // Byte store read-modify-write.
    do_req(1, 0, 0, 16'h0002, 16'h1234, 0); wait_resp();
    do_req(1, 1, 0, 16'h0003, 16'h00AB, 0); wait_resp();
    chk("bstore_latency", last_lat, 3);
    chk("bstore_mem", mem[1], 16'hAB34);
    do_req(0, 0, 0, 16'h0002, 16'h0000, 0); wait_resp();
    chk("bstore_readback", last_data, 16'hAB34);

    // Byte load extension.
    do_req(1, 0, 0, 16'h0000, 16'h80FF, 0); wait_resp();
    do_req(0, 1, 1, 16'h0001, 16'h0000, 0); wait_resp();
    chk("bload_signed_hi", last_data, 16'hFF80);
    chk("bload_latency", last_lat, 2);
    do_req(0, 1, 0, 16'h0001, 16'h0000, 0); wait_resp();
    chk("bload_unsigned_hi", last_data, 16'h0080);
    do_req(0, 1, 1, 16'h0000, 16'h0000, 0); wait_resp();
    chk("bload_signed_lo", last_data, 16'hFFFF);

    // Misaligned word load.
    do_req(1, 0, 0, 16'h0004, 16'h5A5A, 0); wait_resp();
    do_req(0, 0, 0, 16'h0005, 16'h0000, 0); wait_resp();
`ifdef LSU_MISALIGN_TRAP_EN
    chk("misalign_data", last_data, 16'h0000);
    chk("misalign_err", last_err, 1);
`else
    chk("misalign_data", last_data, 16'h5A5A);
    chk("misalign_err", last_err, 0);
`endif

    // Continuous-valid word-load stream.
    base = acc_q.size();
    rc = resp_count;
    for (int i = 0; i < 6; i++)
      do_req(0, 0, 0, 16'($urandom_range(0, 15) * 2), 16'h0000, i != 5);
    wait_resp();
    chk("stream_resp_count", resp_count - rc, 6);
    for (int i = 1; i < 6; i++)
      chk("stream_spacing", acc_q[base+i] - acc_q[base+i-1], 3);

    // Reset during MERGE of a byte store.
    do_req(1, 0, 0, 16'h0000, 16'h1111, 0); wait_resp();
    rc = resp_count;
    do_req(1, 1, 0, 16'h0001, 16'h0055, 0);   // returns in ACCESS
    @(posedge clk); #1 rst = 1'b1;            // now in MERGE
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", req_ready, 1);
    chk("abort_mem", mem[0], 16'h1111);
    chk("abort_no_resp", resp_count - rc, 0);
    @(posedge clk); #1;

    // Randomized traffic over a small address window.
    for (int n = 0; n < 300; n++) begin
      bit we = $urandom_range(0, 1);
      bit byt = $urandom_range(0, 1);
      bit sgn = $urandom_range(0, 1);
      bit keep = ($urandom_range(0, 3) == 0);
      do_req(we, byt, sgn, 16'($urandom_range(0, 31)), 16'($urandom), keep);
      if (!keep) begin
        wait_resp();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    wait_resp();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
